// File: rtl/alu_gate_issue_rv32i.sv
// Issue/writeback sequencer for the RV32I XOR/OR/AND(+I) datapath: decodes one
// request, drives an external combinational gate ALU for one cycle, returns the result.
module alu_gate_issue_rv32i (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_instr,
    input  logic [31:0] req_rs1_val,
    input  logic [31:0] req_rs2_val,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [1:0]  alu_type,
    input  logic [31:0] alu_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [4:0]  rsp_rd,
    output logic [31:0] rsp_data,
    output logic        rsp_wen,
    output logic        rsp_illegal
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [1:0] TYPE_IDLE = 2'b11;

    state_e      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] alu_in1_q, alu_in1_d;
    logic [31:0] alu_in2_q, alu_in2_d;
    logic [1:0]  alu_type_q, alu_type_d;
    logic [4:0]  rsp_rd_q, rsp_rd_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_wen_q, rsp_wen_d;
    logic        rsp_illegal_q, rsp_illegal_d;

    logic        dec_opc_ok_s;
    logic        dec_f3_ok_s;
    logic        dec_legal_s;
    logic [1:0]  dec_type_s;
    logic [31:0] dec_in2_s;

    // Instruction decode: legality, ALU select and second operand.
    always_comb begin
        dec_opc_ok_s = 1'b0;
        dec_f3_ok_s  = 1'b0;
        dec_type_s   = TYPE_IDLE;
        dec_in2_s    = req_rs2_val;
        if (req_instr[6:0] == OPC_I) begin
            dec_opc_ok_s = 1'b1;
            dec_in2_s    = {{20{req_instr[31]}}, req_instr[31:20]};
        end else if ((req_instr[6:0] == OPC_R) && (req_instr[31:25] == 7'b0000000)) begin
            dec_opc_ok_s = 1'b1;
            dec_in2_s    = req_rs2_val;
        end else begin
            dec_opc_ok_s = 1'b0;
            dec_in2_s    = req_rs2_val;
        end
        case (req_instr[14:12])
            3'b100:  begin dec_f3_ok_s = 1'b1; dec_type_s = 2'b00; end
            3'b110:  begin dec_f3_ok_s = 1'b1; dec_type_s = 2'b01; end
            3'b111:  begin dec_f3_ok_s = 1'b1; dec_type_s = 2'b10; end
            default: begin dec_f3_ok_s = 1'b0; dec_type_s = TYPE_IDLE; end
        endcase
        dec_legal_s = dec_opc_ok_s && dec_f3_ok_s;
    end

    // Next-state and next-output logic of the issue FSM.
    always_comb begin
        state_d       = state_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = rsp_valid_q;
        alu_in1_d     = alu_in1_q;
        alu_in2_d     = alu_in2_q;
        alu_type_d    = alu_type_q;
        rsp_rd_d      = rsp_rd_q;
        rsp_data_d    = rsp_data_q;
        rsp_wen_d     = rsp_wen_q;
        rsp_illegal_d = rsp_illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    alu_in1_d   = req_rs1_val;
                    alu_in2_d   = dec_in2_s;
                    rsp_rd_d    = req_instr[11:7];
                    rsp_data_d  = 32'h0000_0000;
                    req_ready_d = 1'b0;
                    if (dec_legal_s) begin
                        alu_type_d    = dec_type_s;
                        rsp_wen_d     = (req_instr[11:7] != 5'd0);
                        rsp_illegal_d = 1'b0;
                        rsp_valid_d   = 1'b0;
                        state_d       = ST_EXEC;
                    end else begin
                        // Illegal ops skip the ALU entirely and answer next cycle.
                        alu_type_d    = TYPE_IDLE;
                        rsp_wen_d     = 1'b0;
                        rsp_illegal_d = 1'b1;
                        rsp_valid_d   = 1'b1;
                        state_d       = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = alu_out;
                alu_type_d  = TYPE_IDLE;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                alu_type_d  = TYPE_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            alu_in1_q     <= 32'h0000_0000;
            alu_in2_q     <= 32'h0000_0000;
            alu_type_q    <= TYPE_IDLE;
            rsp_rd_q      <= 5'd0;
            rsp_data_q    <= 32'h0000_0000;
            rsp_wen_q     <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            alu_in1_q     <= alu_in1_d;
            alu_in2_q     <= alu_in2_d;
            alu_type_q    <= alu_type_d;
            rsp_rd_q      <= rsp_rd_d;
            rsp_data_q    <= rsp_data_d;
            rsp_wen_q     <= rsp_wen_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign alu_in1     = alu_in1_q;
    assign alu_in2     = alu_in2_q;
    assign alu_type    = alu_type_q;
    assign rsp_rd      = rsp_rd_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_wen     = rsp_wen_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_gate_issue_rv32i.sv
// Bench for alu_gate_issue_rv32i: transaction-level reference model checked every
// cycle, directed cases with literal expectations, then randomized traffic.
module tb_alu_gate_issue_rv32i;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_instr = 32'h0;
    logic [31:0] req_rs1_val = 32'h0;
    logic [31:0] req_rs2_val = 32'h0;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic [1:0]  alu_type;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic        rsp_wen, rsp_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    alu_gate_issue_rv32i dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
        .req_rs1_val(req_rs1_val), .req_rs2_val(req_rs2_val),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_type(alu_type), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
        .rsp_data(rsp_data), .rsp_wen(rsp_wen), .rsp_illegal(rsp_illegal)
    );

    always #5 clk = ~clk;

    // External gate ALU
    assign alu_out = (alu_type == 2'b00) ? (alu_in1 ^ alu_in2) :
                     (alu_type == 2'b01) ? (alu_in1 | alu_in2) :
                     (alu_type == 2'b10) ? (alu_in1 & alu_in2) : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference semantics of the request currently presented
    logic        d_legal;
    logic [1:0]  d_type;
    logic [31:0] d_in2, d_res;
    always_comb begin
        logic opc_ok;
        opc_ok  = (req_instr[6:0] == 7'h13) ||
                  (req_instr[6:0] == 7'h33 && req_instr[31:25] == 7'h00);
        d_in2   = (req_instr[6:0] == 7'h13) ? {{20{req_instr[31]}}, req_instr[31:20]} : req_rs2_val;
        d_legal = 1'b0;
        d_type  = 2'd3;
        d_res   = 32'h0;
        case (req_instr[14:12])
            3'd4: begin d_legal = opc_ok; d_type = 2'd0; d_res = req_rs1_val ^ d_in2; end
            3'd6: begin d_legal = opc_ok; d_type = 2'd1; d_res = req_rs1_val | d_in2; end
            3'd7: begin d_legal = opc_ok; d_type = 2'd2; d_res = req_rs1_val & d_in2; end
            default: d_legal = 1'b0;
        endcase
    end

    // Transaction model: one outstanding request, cycles left before it is answered
    bit          chk_en = 0;
    bit          m_pending = 0;
    int          m_wait = 0;
    bit          m_in_known = 0;
    logic [4:0]  m_rd;
    logic [31:0] m_data, m_in1, m_in2;
    logic        m_wen, m_ill;
    logic [1:0]  m_type;

    always @(posedge clk) begin
        if (rst) begin
            chk_en <= 1; m_pending <= 0; m_wait <= 0; m_in_known <= 1;
            m_rd <= 5'd0; m_data <= 32'h0; m_wen <= 1'b0; m_ill <= 1'b0;
            m_in1 <= 32'h0; m_in2 <= 32'h0; m_type <= 2'd3;
        end else if (!m_pending) begin
            if (req_valid) begin
                m_pending  <= 1;
                m_rd       <= req_instr[11:7];
                m_in_known <= d_legal;
                m_in1      <= req_rs1_val;
                m_in2      <= d_in2;
                m_wait     <= d_legal ? 1 : 0;
                m_type     <= d_legal ? d_type : 2'd3;
                m_data     <= d_legal ? d_res : 32'h0;
                m_wen      <= d_legal && (req_instr[11:7] != 5'd0);
                m_ill      <= !d_legal;
            end
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            m_type <= 2'd3;
        end else if (rsp_ready) begin
            m_pending <= 0;
        end
    end

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", {31'b0, req_ready}, {31'b0, !m_pending});
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_pending && m_wait == 0});
            chk("alu_type", {30'b0, alu_type}, {30'b0, m_type});
            if (m_in_known) begin
                chk("alu_in1", alu_in1, m_in1);
                chk("alu_in2", alu_in2, m_in2);
            end
            if (m_pending && m_wait == 0) begin
                chk("rsp_rd", {27'b0, rsp_rd}, {27'b0, m_rd});
                chk("rsp_data", rsp_data, m_data);
                chk("rsp_wen", {31'b0, rsp_wen}, {31'b0, m_wen});
                chk("rsp_illegal", {31'b0, rsp_illegal}, {31'b0, m_ill});
            end
        end
    end

    task automatic send(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                        input int hold, output logic [31:0] data, output logic [4:0] rd,
                        output logic wen, output logic ill, output logic [31:0] in2, output int lat);
        int guard = 0;
        @(negedge clk);
        rsp_ready = 1'b0;
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
        req_valid = 1'b1; req_instr = instr; req_rs1_val = rs1; req_rs2_val = rs2;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin @(negedge clk); lat++; end
        if (!rsp_valid) chk("rsp_valid_timeout", 32'd0, 32'd1);
        repeat (hold) @(negedge clk);
        data = rsp_data; rd = rsp_rd; wen = rsp_wen; ill = rsp_illegal; in2 = alu_in2;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] data, in2, w;
        logic [4:0]  rd;
        logic        wen, ill;
        int          lat, sel;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_alu_type", {30'b0, alu_type}, 32'd3);
        chk("reset_rsp_data", rsp_data, 32'h0);

        send(32'h0020C1B3, 32'hF0F0F0F0, 32'h0FF00FF0, 3, data, rd, wen, ill, in2, lat);
        chk("xor_data", data, 32'hFF00FF00);
        chk("xor_rd", {27'b0, rd}, 32'd3);
        chk("xor_wen", {31'b0, wen}, 32'd1);
        chk("xor_illegal", {31'b0, ill}, 32'd0);
        chk("xor_latency", lat, 32'd2);

        send(32'hFFF26293, 32'h00000010, 32'h12345678, 0, data, rd, wen, ill, in2, lat);
        chk("ori_in2", in2, 32'hFFFFFFFF);
        chk("ori_data", data, 32'hFFFFFFFF);
        chk("ori_rd", {27'b0, rd}, 32'd5);

        send(32'h0F00F313, 32'h12345678, 32'hFFFFFFFF, 1, data, rd, wen, ill, in2, lat);
        chk("andi_data", data, 32'h00000070);
        chk("andi_wen", {31'b0, wen}, 32'd1);
        send(32'h0F00F013, 32'h12345678, 32'hFFFFFFFF, 0, data, rd, wen, ill, in2, lat);
        chk("andi_x0_data", data, 32'h00000070);
        chk("andi_x0_wen", {31'b0, wen}, 32'd0);

        send(32'h002091B3, 32'hAAAA5555, 32'h1, 2, data, rd, wen, ill, in2, lat);
        chk("sll_illegal", {31'b0, ill}, 32'd1);
        chk("sll_wen", {31'b0, wen}, 32'd0);
        chk("sll_data", data, 32'h0);
        chk("sll_latency", lat, 32'd1);

        // Reset while the ALU is being driven
        @(negedge clk);
        req_valid = 1'b1; req_instr = 32'h0020C1B3; req_rs1_val = 32'h1234; req_rs2_val = 32'h4321;
        @(negedge clk);
        req_valid = 1'b0;
        chk("exec_type_before_rst", {30'b0, alu_type}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_mid_alu_in1", alu_in1, 32'h0);
        chk("rst_mid_rsp_wen", {31'b0, rsp_wen}, 32'd0);
        @(negedge clk);
        chk("rst_mid_no_rsp", {31'b0, rsp_valid}, 32'd0);
        send(32'h0020C1B3, 32'hF0F0F0F0, 32'h0FF00FF0, 0, data, rd, wen, ill, in2, lat);
        chk("post_rst_xor_data", data, 32'hFF00FF00);

        // Randomized traffic, occasional resets
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) == 0);
            w = $urandom;
            sel = $urandom_range(0, 7);
            if (sel < 3) begin w[6:0] = 7'h33; w[31:25] = 7'h00; end
            else if (sel < 6) w[6:0] = 7'h13;
            else if (sel == 6) w[6:0] = 7'h33;
            if ($urandom_range(0, 3) != 0) begin
                sel = $urandom_range(0, 2);
                w[14:12] = (sel == 0) ? 3'd4 : (sel == 1) ? 3'd6 : 3'd7;
            end
            req_instr   = w;
            req_rs1_val = $urandom;
            req_rs2_val = $urandom;
            req_valid   = ($urandom_range(0, 2) != 0);
            rsp_ready   = $urandom_range(0, 1);
        end
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_gate_issue_rv32i.md
# alu_gate_issue_rv32i

Issue and writeback sequencer for the RV32I bitwise-logic datapath. It accepts one decoded-register instruction per request: R-type XOR/OR/AND or I-type XORI/ORI/ANDI. It forms the gate ALU operands and select code, captures the ALU result one cycle later, and returns rd, data and write-enable to the register-file writeback stage over a valid/ready handshake. It drives the gate ALU's in1/in2/type inputs and consumes its combinational out.

## Interface
- No parameters; widths fixed at XLEN=32.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_instr  in  32  raw instruction word
- req_rs1_val  in  32  rs1 register value
- req_rs2_val  in  32  rs2 register value (ignored for I-type)
- alu_in1  out  32  operand 1 to gate ALU
- alu_in2  out  32  operand 2 to gate ALU
- alu_type  out  2  select: 00 XOR, 01 OR, 10 AND, 11 idle (ALU returns 0)
- alu_out  in  32  gate ALU result, combinational from alu_in1/alu_in2/alu_type
- rsp_valid  out  1  response present
- rsp_ready  in  1  writeback stage accepts response
- rsp_rd  out  5  destination register, instr[11:7]
- rsp_data  out  32  result
- rsp_wen  out  1  write enable, 1 only for legal instruction with rd≠0
- rsp_illegal  out  1  instruction not supported by this unit

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: req_ready=1, alu_type=11. On req_valid:
  - latch rd, decode, and operands;
  - legal → EXEC;
  - illegal → RESP directly, with rsp_illegal=1, rsp_data=0, rsp_wen=0.
- Decode:
  - opcode 0110011 with funct7=0000000 → in2=rs2_val;
  - opcode 0010011 → in2=sign-extended instr[31:20];
  - in1=rs1_val for both.
  - funct3 100→type 00, 110→01, 111→10.
  - Any other opcode, funct3, or nonzero R-type funct7 is illegal.
- EXEC: drive latched alu_in1/alu_in2/alu_type for exactly one cycle. At the closing edge, register alu_out into rsp_data → RESP.
- RESP: rsp_valid=1. rsp_rd, rsp_data, rsp_wen and rsp_illegal are held stable until rsp_valid&&rsp_ready, then → IDLE.
- alu_in1/alu_in2 hold their last latched values outside EXEC. alu_type returns to 11 in IDLE and RESP.
- rd=0 with a legal op: full execution, rsp_data=result, rsp_wen=0.

## Timing
- Reset (rst=1 at edge): state IDLE, req_ready=1, rsp_valid=0, rsp_rd=0, rsp_data=0, rsp_wen=0, rsp_illegal=0, alu_in1=0, alu_in2=0, alu_type=11.
- Reset takes priority over every state. It aborts EXEC/RESP with no response emitted.
- Legal request accepted at edge N: EXEC during cycle N..N+1, rsp_valid=1 from edge N+1 onward. Minimum 2-cycle latency, minimum 3 cycles between accepts.
- Illegal request accepted at edge N: rsp_valid=1 from edge N+1.
- RESP with rsp_ready=1 at edge M: rsp_valid=0 and req_ready=1 after M. A new request cannot be accepted at M itself.
- req_ready is 0 in EXEC and RESP. req_valid there is ignored and must be held by the source.
- The external ALU must be purely combinational. alu_out is sampled only at the end of EXEC.

## Test plan
- XOR x3,x1,x2: instr 0x0020C1B3, rs1=0xF0F0F0F0, rs2=0x0FF00FF0 → EXEC type=00; rsp_rd=3, rsp_data=0xFF00FF00, rsp_wen=1, rsp_illegal=0, valid 2 cycles after accept.
- ORI x5,x4,-1: instr 0xFFF26293, rs1=0x00000010 → alu_in2=0xFFFFFFFF, type=01, rsp_data=0xFFFFFFFF, rsp_rd=5.
- ANDI x6,x1,0x0F0: instr 0x0F00F313, rs1=0x12345678 → rsp_data=0x00000070. Repeat with rd=0 (instr 0x0F00F013) → rsp_wen=0, same data.
- Illegal SLL: instr 0x002091B3 → rsp_valid 1 cycle after accept, rsp_illegal=1, rsp_wen=0, rsp_data=0, alu_type stays 11.
- Backpressure: hold rsp_ready=0 for 3 cycles in RESP → rsp_* stable and req_ready=0 throughout. Raise rsp_ready → one handshake, then req_ready=1.
- Reset mid-op: assert rst during EXEC → next cycle all outputs at reset values and no rsp_valid. The following request executes normally.
